// File: rtl/fpnew_pkg.sv
// Shared FP types used by the cast unit and its writeback buffer.
package fpnew_pkg;

   // IEEE exception flags, ordered as in the fflags CSR.
   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   localparam int unsigned FFLAGS_W = 5;

endpackage

// File: rtl/fpnew_wb_fifo_mem.sv
// Register-array storage for the writeback buffer: one write port and one
// combinational read port. Contents are intentionally not reset.
module fpnew_wb_fifo_mem #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned ENTRY_W = 39,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   // Write the incoming entry at the write address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fpnew_cast_wb_buffer.sv
// Writeback buffer behind the cast unit: small FIFO of completed conversions
// presented to the FP register file, plus sticky accrued exception flags.
// in_ready_o depends only on registered occupancy, so the cast unit never
// sees writeback backpressure combinationally.
module fpnew_cast_wb_buffer
   import fpnew_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 2,
   parameter type         TagType = logic,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [WIDTH-1:0]    result_i,
   input  status_t             status_i,
   input  logic                extension_bit_i,
   input  TagType              tag_i,
   input  logic                flush_i,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [WIDTH-1:0]    wb_result_o,
   output status_t             wb_status_o,
   output logic                wb_ext_o,
   output TagType              wb_tag_o,
   output logic [FFLAGS_W-1:0] fflags_o,
   input  logic                fflags_clr_i,
   output logic [CNT_W-1:0]    count_o,
   output logic                busy_o
);

   localparam int unsigned TAG_W   = $bits(TagType);
   localparam int unsigned ENTRY_W = WIDTH + FFLAGS_W + 1 + TAG_W;

   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [FFLAGS_W-1:0] fflags;

   logic                push;
   logic                pop;
   logic                empty;
   logic [ENTRY_W-1:0]  wdata;
   logic [ENTRY_W-1:0]  rdata;
   logic [WIDTH-1:0]    rd_result;
   status_t             rd_status;
   logic                rd_ext;
   TagType              rd_tag;
   logic [FFLAGS_W-1:0] head_flags;
   logic [FFLAGS_W-1:0] fflags_nxt;

   assign empty      = (count == '0);
   assign in_ready_o = (count != CNT_W'(DEPTH));
   assign wb_valid_o = !empty;

   // Flush wins over both handshakes, so neither side moves during a flush.
   assign push = in_valid_i && in_ready_o && !flush_i;
   assign pop  = wb_valid_o && wb_ready_i && !flush_i;

   assign wdata = {tag_i, extension_bit_i, status_i, result_i};

   fpnew_wb_fifo_mem #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) i_mem (
      .clk   (clk_i),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign {rd_tag, rd_ext, rd_status, rd_result} = rdata;

   // Head entry outputs, zeroed while empty so stale RAM never leaks out.
   always_comb begin
      wb_result_o = '0;
      wb_status_o = '0;
      wb_ext_o    = 1'b0;
      wb_tag_o    = '0;
      if (!empty) begin
         wb_result_o = rd_result;
         wb_status_o = rd_status;
         wb_ext_o    = rd_ext;
         wb_tag_o    = rd_tag;
      end
   end

   assign head_flags = wb_status_o;

   // Accrued flags: a clear acts on the old value, a retiring entry is then ORed in.
   always_comb begin
      fflags_nxt = fflags_clr_i ? '0 : fflags;
      if (pop) begin
         fflags_nxt = fflags_nxt | head_flags;
      end
   end

   // Pointer, occupancy and flag state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         fflags <= '0;
      end else begin
         fflags <= fflags_nxt;
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
               count <= count + CNT_W'(1);
            end else if (pop && !push) begin
               count <= count - CNT_W'(1);
            end
         end
      end
   end

   assign fflags_o = fflags;
   assign count_o  = count;
   assign busy_o   = !empty;

endmodule

// File: tb/tb_fpnew_cast_wb_buffer.sv
// Directed bench for the cast writeback buffer.
module tb_fpnew_cast_wb_buffer;
   import fpnew_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   result = '0;
   status_t       status = '0;
   logic          ext = 1'b0;
   logic          tag = 1'b0;
   logic          flush = 1'b0;
   logic          wb_valid;
   logic          wb_ready = 1'b0;
   logic [31:0]   wb_result;
   status_t       wb_status;
   logic          wb_ext;
   logic          wb_tag;
   logic [4:0]    fflags;
   logic          fflags_clr = 1'b0;
   logic [1:0]    count;
   logic          busy;

   int total = 0;
   int bad   = 0;

   fpnew_cast_wb_buffer #(.WIDTH(32), .DEPTH(2), .TagType(logic)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .in_valid_i      (in_valid),
      .in_ready_o      (in_ready),
      .result_i        (result),
      .status_i        (status),
      .extension_bit_i (ext),
      .tag_i           (tag),
      .flush_i         (flush),
      .wb_valid_o      (wb_valid),
      .wb_ready_i      (wb_ready),
      .wb_result_o     (wb_result),
      .wb_status_o     (wb_status),
      .wb_ext_o        (wb_ext),
      .wb_tag_o        (wb_tag),
      .fflags_o        (fflags),
      .fflags_clr_i    (fflags_clr),
      .count_o         (count),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] s, input logic t);
      in_valid = v;
      result   = r;
      status   = s;
      tag      = t;
      ext      = r[0];
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
      check({pfx, "_wb_valid"}, 64'(wb_valid), 64'd0);
      check({pfx, "_wb_data"},  {wb_result, 5'(wb_status), wb_ext, wb_tag}, 64'd0);
      check({pfx, "_fflags"},   64'(fflags), 64'd0);
      check({pfx, "_count"},    64'(count), 64'd0);
      check({pfx, "_busy"},     64'(busy), 64'd0);
   endtask

   initial begin
      // reset
      #12;
      check_reset_values("rst");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // single entry, immediate pop
      wb_ready = 1'b1;
      drive(1'b1, 32'h3F800000, 5'b00000, 1'b1);
      check("t1_pre_valid", 64'(wb_valid), 64'd0);
      step();
      drive(1'b0, 32'h0, 5'b00000, 1'b0);
      check("t1_valid", 64'(wb_valid), 64'd1);
      check("t1_result", 64'(wb_result), 64'h3F800000);
      check("t1_tag", 64'(wb_tag), 64'd1);
      check("t1_count", 64'(count), 64'd1);
      step();
      check("t1_valid_gone", 64'(wb_valid), 64'd0);
      check("t1_count0", 64'(count), 64'd0);
      check("t1_result0", 64'(wb_result), 64'd0);

      // backpressure and full handling: A, B, C
      wb_ready = 1'b0;
      drive(1'b1, 32'hAAAA0001, 5'b00000, 1'b0);
      step();
      check("t2_cnt1", 64'(count), 64'd1);
      check("t2_rdy1", 64'(in_ready), 64'd1);
      drive(1'b1, 32'hBBBB0002, 5'b00000, 1'b1);
      step();
      check("t2_cnt2", 64'(count), 64'd2);
      check("t2_full_rdy", 64'(in_ready), 64'd0);
      check("t2_head_a", 64'(wb_result), 64'hAAAA0001);
      drive(1'b1, 32'hCCCC0003, 5'b00000, 1'b0);
      step();
      check("t2_c_held", 64'(count), 64'd2);
      check("t2_head_a_stable", 64'(wb_result), 64'hAAAA0001);
      check("t2_tag_a", 64'(wb_tag), 64'd0);
      wb_ready = 1'b1;
      step();
      check("t2_pop_a_cnt", 64'(count), 64'd1);
      check("t2_head_b", 64'(wb_result), 64'hBBBB0002);
      check("t2_tag_b", 64'(wb_tag), 64'd1);
      check("t2_rdy_again", 64'(in_ready), 64'd1);
      step();
      drive(1'b0, 32'h0, 5'b00000, 1'b0);
      check("t2_pushc_cnt", 64'(count), 64'd1);
      check("t2_head_c", 64'(wb_result), 64'hCCCC0003);
      check("t2_ext_c", 64'(wb_ext), 64'd1);
      step();
      check("t2_empty", 64'(count), 64'd0);
      check("t2_fflags0", 64'(fflags), 64'd0);

      // flag accrual NX then NV
      wb_ready = 1'b0;
      drive(1'b1, 32'h11111111, 5'b00001, 1'b0);
      step();
      drive(1'b1, 32'h22222222, 5'b10000, 1'b1);
      step();
      drive(1'b0, 32'h0, 5'b00000, 1'b0);
      check("t3_head_status", 64'(5'(wb_status)), 64'h01);
      wb_ready = 1'b1;
      step();
      check("t3_ff_nx", 64'(fflags), 64'h01);
      step();
      check("t3_ff_nx_nv", 64'(fflags), 64'h11);

      // clear together with a pop of OF
      wb_ready = 1'b0;
      drive(1'b1, 32'h33333333, 5'b00100, 1'b0);
      step();
      drive(1'b0, 32'h0, 5'b00000, 1'b0);
      check("t4_ff_before", 64'(fflags), 64'h11);
      wb_ready   = 1'b1;
      fflags_clr = 1'b1;
      step();
      fflags_clr = 1'b0;
      check("t4_ff_clr_pop", 64'(fflags), 64'h04);
      check("t4_cnt", 64'(count), 64'd0);

      // flush two NV entries; a concurrent push is ignored
      wb_ready = 1'b0;
      drive(1'b1, 32'h44444444, 5'b10000, 1'b0);
      step();
      drive(1'b1, 32'h55555555, 5'b10000, 1'b1);
      step();
      check("t5_full", 64'(count), 64'd2);
      drive(1'b1, 32'h66666666, 5'b10000, 1'b0);
      wb_ready = 1'b1;
      flush    = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 5'b00000, 1'b0);
      wb_ready = 1'b0;
      check("t5_cnt", 64'(count), 64'd0);
      check("t5_valid", 64'(wb_valid), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_ff_kept", 64'(fflags), 64'h04);
      check("t5_data0", 64'(wb_result), 64'd0);

      // asynchronous reset mid-stream
      drive(1'b1, 32'h77777777, 5'b00010, 1'b1);
      step();
      drive(1'b0, 32'h0, 5'b00000, 1'b0);
      check("t6_cnt1", 64'(count), 64'd1);
      check("t6_busy1", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("t6");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("t6_after_rel", 64'(count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
